// File: rtl/poly_synth_pkg.sv
// Shared types and constants for the polyphonic synthesiser: FSM states,
// waveform-select encodings and the per-key phase increment table.
package poly_synth_pkg;

  typedef enum logic [1:0] {
    ST_LISTEN = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_MIX    = 2'd2,
    ST_PLAY   = 2'd3
  } state_e;

  localparam logic [1:0] WS_SQUARE = 2'b00;
  localparam logic [1:0] WS_SAW    = 2'b01;
  localparam logic [1:0] WS_TRI    = 2'b10;
  localparam logic [1:0] WS_RSVD   = 2'b11;

  // Equal-tempered semitones referenced to 0x1000 at a 16-bit phase;
  // each further twelve keys go up an octave, then scale to phase_w.
  function automatic logic [31:0] note_inc(input int unsigned idx,
                                           input int unsigned phase_w);
    logic [31:0] base;
    case (idx % 12)
      0:       base = 32'd4096;
      1:       base = 32'd4340;
      2:       base = 32'd4598;
      3:       base = 32'd4871;
      4:       base = 32'd5161;
      5:       base = 32'd5468;
      6:       base = 32'd5793;
      7:       base = 32'd6137;
      8:       base = 32'd6502;
      9:       base = 32'd6889;
      10:      base = 32'd7298;
      default: base = 32'd7732;
    endcase
    base = base << (idx / 12);
    if (phase_w >= 16) return base << (phase_w - 16);
    return base >> (16 - phase_w);
  endfunction

endpackage

// File: rtl/poly_synth_voice_shaper.sv
// Combinational waveform shaper: maps the top bits of a voice phase to a
// sample for the selected waveform. One instance is time-shared by all voices.
module voice_shaper
  import poly_synth_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [OUT_W-1:0] p_hi,
  input  logic [1:0]       wave_sel,
  output logic [OUT_W-1:0] sample
);

  logic [OUT_W-1:0] p_dbl;
  assign p_dbl = {p_hi[OUT_W-2:0], 1'b0};

  always_comb begin
    sample = {OUT_W{p_hi[OUT_W-1]}};
    case (wave_sel)
      WS_SAW:  sample = p_hi;
      WS_TRI:  sample = p_hi[OUT_W-1] ? ~p_dbl : p_dbl;
      default: ;
    endcase
  end

endmodule

// File: rtl/poly_synth.sv
// Polyphonic synthesiser: every SAMPLE_DIV cycles, walks all voices through
// one shared shaper, averages them and presents one registered sample.
module poly_synth
  import poly_synth_pkg::*;
#(
  parameter int NUM_KEYS   = 8,
  parameter int OUT_W      = 8,
  parameter int PHASE_W    = 16,
  parameter int SAMPLE_DIV = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [1:0]          wave_sel,
  output logic [OUT_W-1:0]    wave,
  output logic                sample_valid
);

  localparam int KW = $clog2(NUM_KEYS);
  localparam int SW = OUT_W + KW;
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [KW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [NUM_KEYS-1:0]   keys_f_q, keys_f_d;
  logic [1:0]            sel_f_q, sel_f_d;
  logic [OUT_W-1:0]      result_q, result_d;
  logic [OUT_W-1:0]      wave_q, wave_d;
  logic                  valid_q, valid_d;
  logic [PHASE_W-1:0]    phase_q [NUM_KEYS];
  logic [PHASE_W-1:0]    phase_d;
  logic                  phase_we;
  logic [PHASE_W-1:0]    inc_tab [NUM_KEYS];
  logic [PHASE_W-1:0]    phase_rd;
  logic [OUT_W-1:0]      shaped;
  logic [OUT_W-1:0]      voice_add;
  logic                  tick;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_inc
    assign inc_tab[g] = PHASE_W'(note_inc(g, PHASE_W));
  end

  assign tick     = (cnt_q == CW'(SAMPLE_DIV - 1));
  assign cnt_d    = tick ? '0 : cnt_q + 1'b1;
  assign phase_rd = phase_q[idx_q];

  voice_shaper #(.OUT_W(OUT_W)) u_shaper (
    .p_hi     (phase_rd[PHASE_W-1 -: OUT_W]),
    .wave_sel (sel_f_q),
    .sample   (shaped)
  );

  // Released voices contribute midscale so silence mixes to midscale.
  assign voice_add = keys_f_q[idx_q] ? shaped : MID;
  assign phase_d   = keys_f_q[idx_q] ? phase_rd + inc_tab[idx_q] : '0;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    keys_f_d = keys_f_q;
    sel_f_d  = sel_f_q;
    result_d = result_q;
    wave_d   = wave_q;
    valid_d  = 1'b0;
    phase_we = 1'b0;
    case (state_q)
      ST_LISTEN: begin
        if (tick) begin
          keys_f_d = keys;
          sel_f_d  = wave_sel;
          idx_d    = '0;
          sum_d    = '0;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        sum_d    = sum_q + SW'(voice_add);
        phase_we = 1'b1;
        idx_d    = idx_q + 1'b1;
        if (idx_q == KW'(NUM_KEYS - 1)) state_d = ST_MIX;
      end
      ST_MIX: begin
        result_d = sum_q[SW-1:KW];
        state_d  = ST_PLAY;
      end
      ST_PLAY: begin
        wave_d  = result_q;
        valid_d = 1'b1;
        state_d = ST_LISTEN;
      end
      default: state_d = ST_LISTEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LISTEN;
      cnt_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      keys_f_q <= '0;
      sel_f_q  <= WS_SQUARE;
      result_q <= MID;
      wave_q   <= MID;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      keys_f_q <= keys_f_d;
      sel_f_q  <= sel_f_d;
      result_q <= result_d;
      wave_q   <= wave_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) phase_q[i] <= '0;
    end else if (phase_we) begin
      phase_q[idx_q] <= phase_d;
    end
  end

  assign wave         = wave_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_poly_synth.sv
// Self-checking bench for poly_synth with an arithmetic per-frame voice model.
module tb_poly_synth;

  logic       clk;
  logic       rst_n;
  logic [7:0] keys;
  logic [1:0] wave_sel;
  logic [7:0] wave;
  logic       sample_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned m_phase [8];
  int unsigned inc_ref [8] = '{4096, 4340, 4598, 4871, 5161, 5468, 5793, 6137};

  poly_synth #(
    .NUM_KEYS  (8),
    .OUT_W     (8),
    .PHASE_W   (16),
    .SAMPLE_DIV(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .keys        (keys),
    .wave_sel    (wave_sel),
    .wave        (wave),
    .sample_valid(sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame of the reference: average of all voices, then advance phases.
  function automatic int model_frame(input logic [7:0] k, input logic [1:0] s);
    int sum;
    int hi;
    int smp;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) begin
        hi = int'(m_phase[i] / 256);
        case (s)
          2'b01:   smp = hi;
          2'b10:   smp = (m_phase[i] < 32768) ? (2 * hi) % 256 : 255 - ((2 * hi) % 256);
          default: smp = (m_phase[i] >= 32768) ? 255 : 0;
        endcase
        sum += smp;
        m_phase[i] = (m_phase[i] + inc_ref[i]) % 65536;
      end else begin
        sum += 128;
        m_phase[i] = 0;
      end
    end
    return sum / 8;
  endfunction

  task automatic do_reset(input logic [7:0] k, input logic [1:0] s);
    @(negedge clk);
    rst_n = 1'b0;
    keys = k;
    wave_sel = s;
    for (int i = 0; i < 8; i++) m_phase[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (cyc < 64 && !ok) begin
      @(negedge clk);
      cyc++;
      if (sample_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    int cyc;
    int exp;
    @(negedge clk);
    rst_n = 1'b0;
    keys = 8'h00;
    wave_sel = 2'b00;
    for (int i = 0; i < 8; i++) m_phase[i] = 0;
    #1;
    n_checks++;
    if (wave !== 8'h80) begin n_fail++; $display("FAIL reset_wave: got %0h expected 80", wave); end
    n_checks++;
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", sample_valid); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(ok, cyc);
    n_checks++;
    if (!ok || cyc != 26) begin n_fail++; $display("FAIL reset_latency: got %0d cycles (ok=%0b) expected 26", cyc, ok); end
    exp = model_frame(8'h00, 2'b00);
    n_checks++;
    if (wave !== 8'(exp)) begin n_fail++; $display("FAIL reset_first_wave: got %0h expected %0h", wave, exp); end
  endtask

  task automatic test_idle();
    bit ok;
    int cyc;
    do_reset(8'h00, 2'b10);
    wait_valid(ok, cyc);
    for (int f = 0; f < 4; f++) begin
      n_checks++;
      if (wave !== 8'h80) begin n_fail++; $display("FAIL idle_wave f%0d: got %0h expected 80", f, wave); end
      @(negedge clk);
      n_checks++;
      if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL idle_pulse_width f%0d: got %0b expected 0", f, sample_valid); end
      n_checks++;
      if (wave !== 8'h80) begin n_fail++; $display("FAIL idle_hold f%0d: got %0h expected 80", f, wave); end
      wait_valid(ok, cyc);
      n_checks++;
      if (!ok || cyc != 15) begin n_fail++; $display("FAIL idle_period f%0d: got %0d expected 16", f, cyc + 1); end
    end
  endtask

  task automatic test_sawtooth();
    bit ok;
    int cyc;
    int exp;
    do_reset(8'h01, 2'b01);
    for (int f = 0; f < 17; f++) begin
      wait_valid(ok, cyc);
      exp = model_frame(8'h01, 2'b01);
      n_checks++;
      if (!ok || wave !== 8'(exp)) begin n_fail++; $display("FAIL saw f%0d: got %0h expected %0h", f, wave, exp); end
      if (f == 16) begin
        n_checks++;
        if (wave !== 8'h70) begin n_fail++; $display("FAIL saw_wrap: got %0h expected 70", wave); end
      end
    end
  endtask

  task automatic test_square_chord();
    bit ok;
    int cyc;
    int exp;
    do_reset(8'hFF, 2'b00);
    for (int f = 0; f < 12; f++) begin
      wait_valid(ok, cyc);
      exp = model_frame(8'hFF, 2'b00);
      n_checks++;
      if (!ok || wave !== 8'(exp)) begin n_fail++; $display("FAIL square f%0d: got %0h expected %0h", f, wave, exp); end
      if (f == 0 || f == 8) begin
        n_checks++;
        if (wave !== ((f == 0) ? 8'h00 : 8'hFF)) begin n_fail++; $display("FAIL square_edge f%0d: got %0h", f, wave); end
      end
    end
  endtask

  task automatic test_repress();
    bit ok;
    int cyc;
    int exp;
    logic [7:0] k;
    do_reset(8'h08, 2'b01);
    for (int f = 0; f < 8; f++) begin
      wait_valid(ok, cyc);
      k = keys;
      exp = model_frame(k, 2'b01);
      n_checks++;
      if (!ok || wave !== 8'(exp)) begin n_fail++; $display("FAIL repress f%0d: got %0h expected %0h", f, wave, exp); end
      if (f == 6) begin
        n_checks++;
        if (wave !== 8'h70) begin n_fail++; $display("FAIL repress_phase0: got %0h expected 70", wave); end
      end
      keys = (f == 4) ? 8'h00 : 8'h08;
    end
  endtask

  task automatic test_midframe();
    bit ok;
    int cyc;
    int exp;
    logic [7:0] k2, k3;
    logic [1:0] s2, s3;
    do_reset(8'h5A, 2'b10);
    wait_valid(ok, cyc);
    exp = model_frame(8'h5A, 2'b10);
    n_checks++;
    if (!ok || wave !== 8'(exp)) begin n_fail++; $display("FAIL mid_f0: got %0h expected %0h", wave, exp); end
    k2 = 8'hC3; s2 = 2'b01;
    k3 = 8'h3C; s3 = 2'b00;
    keys = k2; wave_sel = s2;
    repeat (8) @(negedge clk);
    keys = k3; wave_sel = s3;
    @(negedge clk);
    keys = 8'hFF; wave_sel = 2'b10;
    @(negedge clk);
    keys = k3; wave_sel = s3;
    wait_valid(ok, cyc);
    exp = model_frame(k2, s2);
    n_checks++;
    if (!ok || wave !== 8'(exp)) begin n_fail++; $display("FAIL mid_unchanged: got %0h expected %0h", wave, exp); end
    wait_valid(ok, cyc);
    exp = model_frame(k3, s3);
    n_checks++;
    if (!ok || wave !== 8'(exp)) begin n_fail++; $display("FAIL mid_next_tick: got %0h expected %0h", wave, exp); end
  endtask

  task automatic test_random();
    bit ok;
    int cyc;
    int exp;
    logic [7:0] k;
    logic [1:0] s;
    k = 8'($urandom_range(0, 255));
    s = 2'($urandom_range(0, 3));
    do_reset(k, s);
    for (int f = 0; f < 30; f++) begin
      wait_valid(ok, cyc);
      exp = model_frame(k, s);
      n_checks++;
      if (!ok || wave !== 8'(exp)) begin
        n_fail++;
        $display("FAIL random f%0d keys=%0h sel=%0d: got %0h expected %0h", f, k, s, wave, exp);
      end
      if ($urandom_range(0, 3) != 0) k = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) s = 2'($urandom_range(0, 3));
      keys = k;
      wave_sel = s;
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int cyc;
    int exp;
    int seen;
    do_reset(8'hFF, 2'b00);
    for (int f = 0; f < 10; f++) begin
      wait_valid(ok, cyc);
      exp = model_frame(8'hFF, 2'b00);
    end
    n_checks++;
    if (!ok || wave !== 8'(exp)) begin n_fail++; $display("FAIL rmid_pre: got %0h expected %0h", wave, exp); end
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wave !== 8'h80) begin n_fail++; $display("FAIL rmid_wave: got %0h expected 80", wave); end
    n_checks++;
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b expected 0", sample_valid); end
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (sample_valid || wave !== 8'h80) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL rmid_hold: got %0d bad cycles expected 0", seen); end
    for (int i = 0; i < 8; i++) m_phase[i] = 0;
    keys = 8'h81; wave_sel = 2'b10;
    rst_n = 1'b1;
    wait_valid(ok, cyc);
    n_checks++;
    if (!ok || cyc != 26) begin n_fail++; $display("FAIL rmid_latency: got %0d cycles expected 26", cyc); end
    exp = model_frame(8'h81, 2'b10);
    n_checks++;
    if (wave !== 8'(exp)) begin n_fail++; $display("FAIL rmid_first: got %0h expected %0h", wave, exp); end
  endtask

  initial begin
    rst_n = 1'b0;
    keys = 8'h00;
    wave_sel = 2'b00;
    test_reset();
    test_idle();
    test_sawtooth();
    test_square_chord();
    test_repress();
    test_midframe();
    test_random();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
